// File: rtl/vec_mem_sequencer.sv
// Serializes scalar / LANES-wide vector load-store requests into single-word
// accesses on a synchronous single-port RAM and reassembles load data.
module vec_mem_sequencer #(
   parameter int unsigned LANES  = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 13
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic                      req_vec,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [LANES*DATA_W-1:0]   req_wdata,
   output logic                      resp_valid,
   output logic [LANES*DATA_W-1:0]   resp_rdata,
   output logic                      busy,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_we,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [CW-1:0] LAST_VEC = CW'(LANES - 1);

   logic [2:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    vec_q, vec_d;
   logic [LANES*DATA_W-1:0] wbuf_q, wbuf_d;
   logic [LANES*DATA_W-1:0] rbuf_q, rbuf_d;
   logic [LANES*DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
   logic                    mem_we_q, mem_we_d;

   logic [CW-1:0]           last;
   logic [CW-1:0]           cnt_nxt;
   logic [CW-1:0]           cnt_prv;

   assign last    = vec_q ? LAST_VEC : '0;
   assign cnt_nxt = cnt_q + CW'(1);
   assign cnt_prv = cnt_q - CW'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      vec_d       = vec_q;
      wbuf_d      = wbuf_q;
      rbuf_d      = rbuf_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = mem_we_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d    = req_write ? S_WRITE : S_READ;
               cnt_d      = '0;
               vec_d      = req_vec;
               wbuf_d     = req_wdata;
               rbuf_d     = '0;
               mem_addr_d = req_addr;
               mem_we_d   = req_write;
               if (req_write) begin
                  mem_wdata_d = req_wdata[DATA_W-1:0];
               end
            end
         end
         S_WRITE: begin
            if (cnt_q == last) begin
               state_d  = S_DONE;
               mem_we_d = 1'b0;
            end else begin
               cnt_d       = cnt_nxt;
               mem_addr_d  = mem_addr_q + ADDR_W'(1);
               mem_wdata_d = wbuf_q[int'(cnt_nxt)*DATA_W +: DATA_W];
            end
         end
         S_READ: begin
            // RAM returns the word issued one cycle earlier, so lane cnt-1 lands now
            if (cnt_q != '0) begin
               rbuf_d[int'(cnt_prv)*DATA_W +: DATA_W] = mem_rdata;
            end
            if (cnt_q == last) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d      = cnt_nxt;
               mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            rbuf_d[int'(cnt_q)*DATA_W +: DATA_W] = mem_rdata;
            rdata_d = rbuf_d;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         vec_q       <= 1'b0;
         wbuf_q      <= '0;
         rbuf_q      <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vec_q       <= vec_d;
         wbuf_q      <= wbuf_d;
         rbuf_q      <= rbuf_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign resp_rdata = rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: synchronous RAM environment plus a per-cycle
// transaction-level reference model and directed/random request streams.
module tb_vec_mem_sequencer;

   localparam int unsigned LANES  = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned VW     = LANES * DATA_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic              req_vec = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [VW-1:0]     req_wdata = '0;
   logic              resp_valid;
   logic [VW-1:0]     resp_rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata = '0;

   vec_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM environment and the model's golden copy of its contents
   logic [DATA_W-1:0] ram  [DEPTH];
   logic [DATA_W-1:0] gold [DEPTH];

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         ram[i]  = i * 32'h9E37_79B1;
         gold[i] = i * 32'h9E37_79B1;
      end
   end

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction described by its timeline
   int            cyc = 0;
   bit            active = 0;
   int            a_T, a_n, a_resp;
   bit            a_wr;
   logic [ADDR_W-1:0] a_base;
   logic [VW-1:0] a_data, a_rd;
   logic [VW-1:0] exp_rdata = '0;
   logic [ADDR_W-1:0] wq [$];

   always @(negedge clk) begin
      int k;
      bit exp_ready, exp_resp, in_xfer;
      logic [ADDR_W-1:0] ea;
      cyc++;
      if (!rst) begin
         active    = 0;
         exp_rdata = '0;
         chk("rst_ready", req_ready, 1);
         chk("rst_busy", busy, 0);
         chk("rst_resp", resp_valid, 0);
         chk("rst_we", mem_we, 0);
         chk("rst_addr", mem_addr, 0);
         chk("rst_wdata", mem_wdata, 0);
         chk("rst_rdata", resp_rdata, 0);
      end else begin
         if (active && cyc > a_resp) active = 0;
         k         = cyc - a_T;
         exp_ready = !active;
         in_xfer   = active && k >= 1 && k <= a_n;
         exp_resp  = active && cyc == a_resp;
         if (exp_resp && !a_wr) exp_rdata = a_rd;
         chk("ready", req_ready, exp_ready);
         chk("busy", busy, !exp_ready);
         chk("resp_valid", resp_valid, exp_resp);
         chk("mem_we", mem_we, in_xfer && a_wr);
         chk("resp_rdata", resp_rdata, exp_rdata);
         if (in_xfer) begin
            ea = a_base + ADDR_W'(k - 1);
            chk("mem_addr", mem_addr, ea);
            if (a_wr) begin
               chk("mem_wdata", mem_wdata, a_data[(k-1)*DATA_W +: DATA_W]);
               gold[ea] = a_data[(k-1)*DATA_W +: DATA_W];
            end
         end
         if (mem_we) wq.push_back(mem_addr);
         if (exp_ready && req_valid) begin
            active = 1;
            a_T    = cyc;
            a_wr   = req_write;
            a_n    = req_vec ? int'(LANES) : 1;
            a_base = req_addr;
            a_data = req_wdata;
            a_resp = cyc + (req_write ? a_n + 1 : a_n + 2);
            a_rd   = '0;
            if (!req_write)
               for (int i = 0; i < a_n; i++)
                  a_rd[i*DATA_W +: DATA_W] = gold[req_addr + ADDR_W'(i)];
         end
      end
   end

   function automatic logic [VW-1:0] rnd_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < int'(LANES); i++) v[i*DATA_W +: DATA_W] = $urandom;
      return v;
   endfunction

   // Presents one request, waits for acceptance and completion; lat = cycles T -> resp
   task automatic issue(input bit wr, input bit vec, input logic [ADDR_W-1:0] addr,
                        input logic [VW-1:0] data, output int lat);
      int w;
      @(posedge clk); #1;
      req_valid = 1; req_write = wr; req_vec = vec; req_addr = addr; req_wdata = data;
      w = 0;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         w++;
         if (w > 100) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no ready want ready");
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 0; req_write = $urandom; req_vec = $urandom;
      req_addr = ADDR_W'($urandom); req_wdata = rnd_vec();
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (resp_valid) begin lat = k; break; end
      end
   endtask

   initial begin
      int lat;
      logic [VW-1:0] d, x;
      logic [VW-1:0] scal_exp;
      repeat (3) @(posedge clk);
      #3 rst = 1;

      // vector store then load, base 0x0100
      for (int i = 0; i < int'(LANES); i++) d[i*DATA_W +: DATA_W] = 32'hA000_0000 + i;
      issue(1, 1, 13'h0100, d, lat);
      chk("vst_latency", lat, 17);
      issue(0, 1, 13'h0100, rnd_vec(), lat);
      chk("vld_latency", lat, 18);
      chk("vld_lane0", resp_rdata[31:0], 32'hA000_0000);
      chk("vld_lane15", resp_rdata[511:480], 32'hA000_000F);

      // scalar store/load at 0x0005
      d = rnd_vec(); d[31:0] = 32'hDEAD_BEEF;
      issue(1, 0, 13'h0005, d, lat);
      chk("sst_latency", lat, 2);
      issue(0, 0, 13'h0005, rnd_vec(), lat);
      chk("sld_latency", lat, 3);
      scal_exp = '0; scal_exp[31:0] = 32'hDEAD_BEEF;
      chk("sld_data", resp_rdata, scal_exp);

      // wrap-around vector store/load at 0x1FFE
      x = rnd_vec();
      wq.delete();
      issue(1, 1, 13'h1FFE, x, lat);
      chk("wrap_count", wq.size(), 16);
      chk("wrap_a0", wq[0], 13'h1FFE);
      chk("wrap_a1", wq[1], 13'h1FFF);
      chk("wrap_a2", wq[2], 13'h0000);
      chk("wrap_a15", wq[15], 13'h000D);
      issue(0, 1, 13'h1FFE, rnd_vec(), lat);
      chk("wrap_load", resp_rdata, x);

      // a store leaves the last load data in place
      issue(1, 1, 13'h0200, rnd_vec(), lat);
      chk("store_keeps_rdata", resp_rdata, x);

      // reset at T+5 of a vector store
      @(posedge clk); #1;
      req_valid = 1; req_write = 1; req_vec = 1; req_addr = 13'h0300; req_wdata = rnd_vec();
      @(negedge clk);
      chk("pre_rst_ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 0;
      repeat (4) @(posedge clk);
      #1 rst = 0;
      #1 chk("rst_we_async", mem_we, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1;
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (resp_valid) lat++;
      end
      chk("post_rst_no_resp", lat, 0);
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_rdata", resp_rdata, 0);

      // backpressure: req_valid held with changing payloads
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         req_valid = 1;
         req_write = ($urandom_range(0, 2) != 0);
         req_vec   = $urandom;
         req_addr  = ADDR_W'($urandom_range(0, 63));
         req_wdata = rnd_vec();
      end
      @(posedge clk); #1 req_valid = 0;

      // random requests with idle gaps
      for (int r = 0; r < 40; r++) begin
         issue($urandom, $urandom, ADDR_W'($urandom), rnd_vec(), lat);
         chk("rand_done", lat > 0, 1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sits directly downstream of the CPU's memory port and upstream of the single-port word-wide data RAM.
- Accepts one scalar or 16-lane vector load/store request at a time.
- Serializes each request into per-word RAM accesses and returns assembled 16x32 read data with a one-cycle completion pulse.
- Backpressures the CPU with req_ready and busy while a transfer is in flight.

Parameters:
- LANES, 16, number of 32-bit lanes per vector access.
- DATA_W, 32, lane and RAM word width.
- ADDR_W, 13, word address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_vec  in  1  1=vector (LANES words), 0=scalar (1 word, lane 0).
- req_addr  in  ADDR_W  base word address.
- req_wdata  in  LANES*DATA_W  store data; lane i at bits [i*32+:32].
- resp_valid  out  1  one-cycle pulse on completion of any request.
- resp_rdata  out  LANES*DATA_W  load result; held until next load completes.
- busy  out  1  high from acceptance until the cycle resp_valid is high, inclusive.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after mem_addr is presented.

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=1; resp_valid=0; busy=0; mem_we=0; mem_addr=0; mem_wdata=0; resp_rdata=0; lane counter=0.
- Reset mid-transfer aborts immediately: mem_we drops asynchronously and no resp_valid is produced.
- Handshake: a request is accepted in cycle T when req_valid && req_ready.
  - req_addr, req_write, req_vec and the full req_wdata are captured at T; inputs are don't-care afterwards.
  - req_valid while not ready is ignored (not queued).
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE -> WRITE if req_write; IDLE -> READ otherwise. n = LANES if req_vec, else 1.
- WRITE: cycles T+1..T+n drive mem_we=1, mem_addr=(base+i) mod 2^ADDR_W, mem_wdata=lane i, for i=0..n-1. Next state is DONE.
- READ: cycles T+1..T+n drive mem_we=0 and mem_addr=base+i.
  - mem_rdata sampled in cycle T+2+i is written into lane i.
  - After the last issue, state goes to DRAIN for one cycle to capture the final word, then DONE.
- Scalar load: lane 0 = word; lanes 1..LANES-1 are cleared to 0.
- DONE: resp_valid=1 for exactly one cycle, then IDLE with req_ready=1 in the next cycle.
  - No back-to-back acceptance in the DONE cycle.
- Latency from acceptance T to the resp_valid cycle:
  - vector store T+17; scalar store T+2.
  - vector load T+18; scalar load T+3.
- resp_rdata changes only when a load completes; stores leave it unchanged.
- Outside WRITE: mem_we=0. mem_addr and mem_wdata hold their last values (no glitch requirement).
- Address wrap: base=8190 vector touches 8190, 8191, 0, 1, ..., 13.
- Unaligned bases are legal.
- busy = !req_ready throughout non-reset operation.

Test Plan:
- Reset during operation: assert rst=0 at T+5 of a vector store -> mem_we=0 immediately; after release, req_ready=1, resp_valid never pulses, resp_rdata=0.
- Vector store then load: store base=0x0100, lane i = 0xA000_0000+i -> mem_we high T+1..T+16 with addresses 0x0100..0x010F, resp_valid at T+17. Load the same base -> resp_valid at T'+18, lane i = 0xA000_0000+i.
- Scalar store/load: store addr 0x0005 data 0xDEADBEEF -> one mem_we cycle at T+1, resp_valid at T+2. Load 0x0005 -> resp_valid at T+3, lane0=0xDEADBEEF, lanes1..15=0.
- Wrap-around: vector store base=0x1FFE -> write addresses 0x1FFE, 0x1FFF, 0x0000..0x000D in order. Vector load readback matches.
- Backpressure: hold req_valid=1 continuously with changing payloads -> acceptance only when req_ready=1. Each accepted request completes exactly once, and requests presented while busy have no effect on RAM.
- Store preserves read data: load returns X, then a vector store -> resp_rdata still equals X after the store's resp_valid.
